ddr_port_arbiter: RTL and testbench
===================================

// Module: ddr_port_arbiter
// PURPOSE
//  Shares the single DDR front-end (enter_state/outputs request side) between NUM_PORTS clients.
//  Round-robin picks a client, drives ADDRESS_REQ/WE/DATA_W/DO_ACT until COMMAND_LATCHED, returns
//  one-cycle GNT, and tags reads to route DATA_R back to the issuing client READ_LATENCY cycles later.
//  Sits between on-chip masters and the DDR command sequencer.
// PARAMETERS
//  NUM_PORTS        4     number of requesting clients (2..8)
//  ADDR_W           28    request address width ({row,bank,column})
//  DATA_W           32    read/write word width
//  READ_LATENCY     4     cycles from COMMAND_LATCHED edge to valid DATA_R
//  REFRESH_INTERVAL 1560  cycles between refresh strobe toggles (DDR_ARB_REFRESH_EN only)
// PORTS
//  CLK            in   1                  system clock, all logic on posedge
//  RST            in   1                  asynchronous reset, active low
//  REQ            in   NUM_PORTS          per-client request, held until GNT
//  REQ_WE         in   NUM_PORTS          per-client 1=write 0=read, stable with REQ
//  REQ_ADDR       in   NUM_PORTS*ADDR_W   per-client address, client i at [i*ADDR_W +: ADDR_W]
//  REQ_WDATA      in   NUM_PORTS*DATA_W   per-client write data, same packing
//  GNT            out  NUM_PORTS          one-hot, combinational: owner's command latched this cycle
//  RDATA_VALID    out  NUM_PORTS          one-hot registered pulse: RDATA belongs to that client
//  RDATA          out  DATA_W             registered read data
//  ADDRESS_REQ    out  ADDR_W             to sequencer
//  WE             out  1                  to sequencer/outputs
//  DATA_W_OUT     out  DATA_W             write data to outputs block
//  DO_ACT         out  1                  command request to sequencer
//  COMMAND_LATCHED in  1                  sequencer accepted current command
//  DATA_R         in   DATA_W             read data from outputs block
//  REFRESH_STROBE out  1                  toggle-type refresh request to sequencer
// BEHAVIOUR
//  - Reset (RST low, async): DO_ACT=0, WE=0, ADDRESS_REQ=0, DATA_W_OUT=0, RDATA=0, RDATA_VALID=0,
//    REFRESH_STROBE=0, rr pointer=0, state IDLE, all read tags cleared. Reset mid-transfer drops
//    in-flight reads silently: no RDATA_VALID follows.
//  - FSM: IDLE, ISSUE.
//    IDLE: if |REQ, pick winner at next edge, load its addr/we/wdata into output regs, DO_ACT<=1 -> ISSUE.
//    ISSUE: outputs held stable while COMMAND_LATCHED=0. GNT[owner]=COMMAND_LATCHED.
//    At the edge where COMMAND_LATCHED=1: candidates = REQ & ~owner. If any, load next winner and
//    stay ISSUE (back-to-back, DO_ACT stays 1). Otherwise DO_ACT<=0 -> IDLE.
//  - Round-robin: search starts at the port after the last granted one and wraps at NUM_PORTS-1 -> 0.
//    Pointer updates only on a latch. A single requester is never starved by its own mask.
//  - Clients deassert REQ or present a new request on the edge after GNT. A REQ drop before GNT is
//    a protocol violation with undefined behaviour.
//  - Read tag: at a latch with WE=0, push {valid,owner} into a READ_LATENCY+1 deep shift pipe.
//    - Latch at edge t -> sample DATA_R at edge t+READ_LATENCY -> RDATA/RDATA_VALID[owner] visible
//      from t+READ_LATENCY for one cycle.
//    - Overlapping reads are independent stages. Writes push invalid tags.
//  - GNT is zero whenever state==IDLE.
// CONFIGURATION
//  DDR_ARB_REFRESH_EN defined:
//    - 16-bit down counter reloads to REFRESH_INTERVAL-1 and toggles REFRESH_STROBE on reaching 0.
//    - Free-running; first toggle REFRESH_INTERVAL cycles after reset release.
//  Not defined: REFRESH_STROBE is constant 0 and refresh comes from an external source; no counter logic.
// STRUCTURE
//  - Shared package ddr_pkg:
//    - command encodings (PRCH/ACTV/READ/WRTE/ARSR/NOOP)
//    - DDR_ADDR_W=28, DDR_DATA_W=32, DDR_READ_LATENCY=4
//    - port-id width function clog2(NUM_PORTS)
//  - Sub-module ddr_read_tag_pipe (params DEPTH, ID_W): shift register of {valid,id} with async
//    reset; outputs the tag at stage READ_LATENCY-1.
//  - Round-robin picker is inline combinational logic (double-width mask-and-priority method).
// TESTING
//  1 Reset: hold RST=0 with REQ=4'hF -> all outputs 0, DO_ACT=0; release -> DO_ACT=1 next edge, owner port0.
//  2 RR fairness: REQ=4'hF constant, COMMAND_LATCHED every 2nd cycle -> GNT order 1,2,4,8,1,...
//    no gaps in DO_ACT.
//  3 Read return: port2 reads addr 28'h0012345, latch at cycle 10, DATA_R=32'hCAFEF00D at cycle 14
//    -> RDATA_VALID=4'b0100 and RDATA=32'hCAFEF00D in cycle 14 only.
//  4 Overlap: port0 read latched c10, port3 read latched c11 -> valids 0001 at c14 and 1000 at c15.
//  5 Write: port1 REQ_WE=1, wdata 32'hDEADBEEF -> DATA_W_OUT/WE held until latch, GNT=0010, no RDATA_VALID.
//  6 Async reset at cycle 12 with 2 reads in flight -> outputs clear immediately, no RDATA_VALID after;
//    with DDR_ARB_REFRESH_EN, REFRESH_INTERVAL=8 -> strobe toggles every 8 cycles.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared DDR definitions: command encodings, default widths/latency and the port-id width helper.
package ddr_pkg;

  typedef enum logic [2:0] {
    CMD_PRCH = 3'd0,
    CMD_ACTV = 3'd1,
    CMD_READ = 3'd2,
    CMD_WRTE = 3'd3,
    CMD_ARSR = 3'd4,
    CMD_NOOP = 3'd5
  } ddr_cmd_e;

  localparam int unsigned DDR_ADDR_W       = 28;
  localparam int unsigned DDR_DATA_W       = 32;
  localparam int unsigned DDR_READ_LATENCY = 4;

  // Width of a port index; never narrower than one bit.
  function automatic int unsigned port_id_w(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/ddr_read_tag_pipe.sv
// Shift pipe of {valid,id} read tags; the tap is the last storage stage, the final
// stage of the DEPTH-deep pipe is the consumer's registered read-valid output.
module ddr_read_tag_pipe #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned ID_W  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push_vld,
  input  logic [ID_W-1:0] i_push_id,
  output logic            o_tag_vld,
  output logic [ID_W-1:0] o_tag_id
);

  localparam int unsigned STAGES = DEPTH - 1;

  logic            r_vld [STAGES];
  logic [ID_W-1:0] r_id  [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_vld[k] <= 1'b0;
        r_id[k]  <= '0;
      end
    end else begin
      r_vld[0] <= i_push_vld;
      r_id[0]  <= i_push_id;
      for (int k = 1; k < int'(STAGES); k++) begin
        r_vld[k] <= r_vld[k-1];
        r_id[k]  <= r_id[k-1];
      end
    end
  end

  assign o_tag_vld = r_vld[STAGES-1];
  assign o_tag_id  = r_id[STAGES-1];

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR command front-end between NUM_PORTS clients, with read routing.
// Optional free-running refresh strobe generator enabled by DDR_ARB_REFRESH_EN.
module ddr_port_arbiter
  import ddr_pkg::*;
#(
  parameter int unsigned NUM_PORTS        = 4,
  parameter int unsigned ADDR_W           = DDR_ADDR_W,
  parameter int unsigned DATA_W           = DDR_DATA_W,
  parameter int unsigned READ_LATENCY     = DDR_READ_LATENCY,
  parameter int unsigned REFRESH_INTERVAL = 1560
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_PORTS-1:0]        REQ,
  input  logic [NUM_PORTS-1:0]        REQ_WE,
  input  logic [NUM_PORTS*ADDR_W-1:0] REQ_ADDR,
  input  logic [NUM_PORTS*DATA_W-1:0] REQ_WDATA,
  output logic [NUM_PORTS-1:0]        GNT,
  output logic [NUM_PORTS-1:0]        RDATA_VALID,
  output logic [DATA_W-1:0]           RDATA,
  output logic [ADDR_W-1:0]           ADDRESS_REQ,
  output logic                        WE,
  output logic [DATA_W-1:0]           DATA_W_OUT,
  output logic                        DO_ACT,
  input  logic                        COMMAND_LATCHED,
  input  logic [DATA_W-1:0]           DATA_R,
  output logic                        REFRESH_STROBE
);

  localparam int unsigned ID_W = port_id_w(NUM_PORTS);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  if (REFRESH_INTERVAL < 2 || REFRESH_INTERVAL > 65536) begin : g_bad_refresh_interval
    $error("REFRESH_INTERVAL must fit the 16-bit refresh counter");
  end

  logic [0:0]            r_state, w_state_nxt;
  logic [ID_W-1:0]       r_owner, w_owner_nxt, r_ptr, w_ptr_nxt;
  logic                  r_do_act, w_do_act_nxt, w_load;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata, r_rdata;
  logic [NUM_PORTS-1:0]  r_rdata_valid;
  logic                  w_latch, w_any, w_sel_we;
  logic [NUM_PORTS-1:0]  w_owner_oh, w_cand;
  logic [2*NUM_PORTS-1:0] w_dbl;
  logic [ID_W-1:0]       w_owner_inc, w_start, w_win;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [DATA_W-1:0]     w_sel_wdata;
  logic                  w_tag_vld;
  logic [ID_W-1:0]       w_tag_id;

  assign w_latch     = (r_state == S_ISSUE) && COMMAND_LATCHED;
  assign w_owner_oh  = NUM_PORTS'(1) << r_owner;
  assign w_owner_inc = (r_owner == ID_W'(NUM_PORTS - 1)) ? '0 : r_owner + 1'b1;
  // The current owner is masked at a latch so the next command goes to someone else.
  assign w_cand      = w_latch ? (REQ & ~w_owner_oh) : REQ;
  assign w_start     = w_latch ? w_owner_inc : r_ptr;
  assign w_dbl       = {w_cand, w_cand};
  assign w_any       = |w_cand;

  // Lowest requester at or above the start index in the doubled vector wins, wrapping naturally.
  always_comb begin
    w_win = '0;
    for (int i = 2*NUM_PORTS-1; i >= 0; i--) begin
      if (w_dbl[i] && (i >= int'(w_start))) begin
        w_win = (i >= int'(NUM_PORTS)) ? ID_W'(i - int'(NUM_PORTS)) : ID_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (w_win == ID_W'(p)) begin
        w_sel_addr  = REQ_ADDR[p*ADDR_W +: ADDR_W];
        w_sel_wdata = REQ_WDATA[p*DATA_W +: DATA_W];
        w_sel_we    = REQ_WE[p];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_do_act_nxt = r_do_act;
    w_ptr_nxt    = r_ptr;
    w_owner_nxt  = r_owner;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt  = S_ISSUE;
          w_do_act_nxt = 1'b1;
          w_load       = 1'b1;
        end
      end
      S_ISSUE: begin
        if (COMMAND_LATCHED) begin
          w_ptr_nxt = w_start;
          if (w_any) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt  = S_IDLE;
            w_do_act_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_load) w_owner_nxt = w_win;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_do_act <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_do_act <= w_do_act_nxt;
      if (w_load) begin
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
    end
  end

  ddr_read_tag_pipe #(
    .DEPTH (READ_LATENCY + 1),
    .ID_W  (ID_W)
  ) u_tag_pipe (
    .clk        (CLK),
    .rst_n      (RST),
    .i_push_vld (w_latch && !r_we),
    .i_push_id  (r_owner),
    .o_tag_vld  (w_tag_vld),
    .o_tag_id   (w_tag_id)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rdata_valid <= '0;
      r_rdata       <= '0;
    end else begin
      r_rdata_valid <= w_tag_vld ? (NUM_PORTS'(1) << w_tag_id) : '0;
      if (w_tag_vld) r_rdata <= DATA_R;
    end
  end

`ifdef DDR_ARB_REFRESH_EN
  localparam logic [15:0] REF_RELOAD = 16'(REFRESH_INTERVAL - 1);
  logic [15:0] r_ref_cnt;
  logic        r_ref_strobe;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ref_cnt    <= REF_RELOAD;
      r_ref_strobe <= 1'b0;
    end else if (r_ref_cnt == '0) begin
      r_ref_cnt    <= REF_RELOAD;
      r_ref_strobe <= ~r_ref_strobe;
    end else begin
      r_ref_cnt <= r_ref_cnt - 16'd1;
    end
  end

  assign REFRESH_STROBE = r_ref_strobe;
`else
  assign REFRESH_STROBE = 1'b0;
`endif

  assign GNT         = w_latch ? w_owner_oh : '0;
  assign DO_ACT      = r_do_act;
  assign WE          = r_we;
  assign ADDRESS_REQ = r_addr;
  assign DATA_W_OUT  = r_wdata;
  assign RDATA       = r_rdata;
  assign RDATA_VALID = r_rdata_valid;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed and randomized bench for ddr_port_arbiter against a cycle-level behavioural model.
module tb_ddr_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int RL = 4;
  localparam int RI = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ, REQ_WE, GNT, RDATA_VALID;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*DW-1:0] REQ_WDATA;
  logic [DW-1:0]   RDATA, DATA_W_OUT, DATA_R;
  logic [AW-1:0]   ADDRESS_REQ;
  logic            WE, DO_ACT, COMMAND_LATCHED, REFRESH_STROBE;

  int total, bad, cyc;
  bit            m_busy, m_act, m_we;
  int            m_owner, m_next;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [N-1:0]  m_rv, m_gnt_prev, obs_gnt;
  bit            s_vld [64];
  int            s_port [64];

  always #5 CLK = ~CLK;

  ddr_port_arbiter #(
    .NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .REFRESH_INTERVAL(RI)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .GNT(GNT), .RDATA_VALID(RDATA_VALID), .RDATA(RDATA), .ADDRESS_REQ(ADDRESS_REQ), .WE(WE),
    .DATA_W_OUT(DATA_W_OUT), .DO_ACT(DO_ACT), .COMMAND_LATCHED(COMMAND_LATCHED), .DATA_R(DATA_R),
    .REFRESH_STROBE(REFRESH_STROBE)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_act = 0; m_we = 0; m_owner = 0; m_next = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_rv = '0; m_gnt_prev = '0; cyc = 0;
    for (int k = 0; k < 64; k++) s_vld[k] = 0;
  endtask

  // Clients whose previous request was granted, or that are idle, may pick a new request.
  task automatic rand_clients(input int pct);
    for (int p = 0; p < N; p++) begin
      if (m_gnt_prev[p] || !REQ[p]) begin
        REQ[p]                = ($urandom % 100) < pct;
        REQ_WE[p]             = $urandom % 2;
        REQ_ADDR[p*AW +: AW]  = AW'($urandom);
        REQ_WDATA[p*DW +: DW] = $urandom;
      end
    end
  endtask

  // Checks outputs in the low phase, then advances the model across the coming edge.
  task automatic cycle();
    logic [N-1:0] exp_gnt, cand;
    bit latch, exp_ref;
    int w, slot;
    #1;
    latch   = m_busy && COMMAND_LATCHED;
    exp_gnt = latch ? (N'(1) << m_owner) : '0;
    obs_gnt = GNT;
`ifdef DDR_ARB_REFRESH_EN
    exp_ref = ((cyc / RI) % 2) == 1;
`else
    exp_ref = 0;
`endif
    chk("gnt", 64'(GNT), 64'(exp_gnt));
    chk("do_act", 64'(DO_ACT), 64'(m_act));
    if (m_act) begin
      chk("address_req", 64'(ADDRESS_REQ), 64'(m_addr));
      chk("we", 64'(WE), 64'(m_we));
      chk("data_w_out", 64'(DATA_W_OUT), 64'(m_wdata));
    end
    chk("rdata_valid", 64'(RDATA_VALID), 64'(m_rv));
    if (m_rv != '0) chk("rdata", 64'(RDATA), 64'(m_rdata));
    chk("refresh_strobe", 64'(REFRESH_STROBE), 64'(exp_ref));

    slot = cyc % 64;
    if (s_vld[slot]) begin
      m_rv = N'(1) << s_port[slot];
      m_rdata = DATA_R;
      s_vld[slot] = 0;
    end else begin
      m_rv = '0;
    end
    if (latch && !m_we) begin
      s_vld[(cyc + RL) % 64]  = 1;
      s_port[(cyc + RL) % 64] = m_owner;
    end
    if (latch) m_next = (m_owner + 1) % N;
    if (!m_busy || latch) begin
      cand = REQ;
      if (latch) cand[m_owner] = 1'b0;
      if (cand != '0) begin
        w = m_next;
        for (int k = 0; k < N; k++) begin
          w = (m_next + k) % N;
          if (cand[w]) break;
        end
        m_owner = w;
        m_addr  = REQ_ADDR[w*AW +: AW];
        m_wdata = REQ_WDATA[w*DW +: DW];
        m_we    = REQ_WE[w];
        m_busy  = 1;
        m_act   = 1;
      end else begin
        m_busy = 0;
        m_act  = 0;
      end
    end
    m_gnt_prev = exp_gnt;
    cyc++;
    @(negedge CLK);
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (!m_busy && REQ == '0) return;
      rand_clients(0);
      COMMAND_LATCHED = 1'b1;
      DATA_R = $urandom;
      cycle();
    end
    chk("drain_timeout", 64'(DO_ACT), 64'(0));
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_gnt"}, 64'(GNT), 64'(0));
    chk({pfx, "_do_act"}, 64'(DO_ACT), 64'(0));
    chk({pfx, "_we"}, 64'(WE), 64'(0));
    chk({pfx, "_addr"}, 64'(ADDRESS_REQ), 64'(0));
    chk({pfx, "_wdata"}, 64'(DATA_W_OUT), 64'(0));
    chk({pfx, "_rdata"}, 64'(RDATA), 64'(0));
    chk({pfx, "_rvalid"}, 64'(RDATA_VALID), 64'(0));
    chk({pfx, "_refresh"}, 64'(REFRESH_STROBE), 64'(0));
  endtask

  initial begin
    total = 0; bad = 0;
    RST = 1'b0; REQ = '1; REQ_WE = '0; COMMAND_LATCHED = 1'b0; DATA_R = '0;
    for (int p = 0; p < N; p++) begin
      REQ_ADDR[p*AW +: AW]  = AW'($urandom);
      REQ_WDATA[p*DW +: DW] = $urandom;
    end
    model_reset();

    // Reset held with all clients requesting.
    repeat (3) @(negedge CLK);
    #1 chk_all_zero("reset");
    @(negedge CLK);
    RST = 1'b1;

    // Round-robin order with everyone requesting and a latch every second cycle.
    for (int i = 0; i < 17; i++) begin
      COMMAND_LATCHED = (i % 2) == 1;
      DATA_R = $urandom;
      cycle();
      if (i == 0) begin
        #1;
        chk("rst_do_act", 64'(DO_ACT), 64'(1));
        chk("rst_owner0", 64'(ADDRESS_REQ), 64'(REQ_ADDR[AW-1:0]));
      end
      if (i >= 1) chk("rr_no_gap", 64'(DO_ACT), 64'(1));
      if (i % 2 == 1) chk("rr_order", 64'(obs_gnt), 64'(N'(1) << (((i - 1) / 2) % N)));
    end

    // Single read from port 2.
    drain();
    REQ[2] = 1'b1; REQ_WE[2] = 1'b0; REQ_ADDR[2*AW +: AW] = 28'h0012345;
    COMMAND_LATCHED = 1'b0; DATA_R = '0;
    cycle();
    cycle();
    COMMAND_LATCHED = 1'b1;
    cycle();
    chk("t3_gnt", 64'(obs_gnt), 64'(4'b0100));
    COMMAND_LATCHED = 1'b0; DATA_R = 32'hCAFEF00D;
    for (int k = 0; k < RL; k++) begin
      rand_clients(0);
      cycle();
    end
    #1;
    chk("t3_rvalid", 64'(RDATA_VALID), 64'(4'b0100));
    chk("t3_rdata", 64'(RDATA), 64'(32'hCAFEF00D));
    cycle();
    #1 chk("t3_rvalid_once", 64'(RDATA_VALID), 64'(0));

    // Two overlapping reads latched back to back.
    drain();
    REQ = 4'b1001; REQ_WE = '0; COMMAND_LATCHED = 1'b0;
    cycle();
    COMMAND_LATCHED = 1'b1; DATA_R = $urandom;
    cycle();
    rand_clients(0);
    cycle();
    COMMAND_LATCHED = 1'b0;
    for (int k = 0; k < RL + 2; k++) begin
      rand_clients(0);
      DATA_R = $urandom;
      cycle();
    end

    // Write from port 1 held until latch.
    drain();
    REQ[1] = 1'b1; REQ_WE[1] = 1'b1; REQ_WDATA[1*DW +: DW] = 32'hDEADBEEF; COMMAND_LATCHED = 1'b0;
    cycle();
    cycle();
    #1;
    chk("t5_we", 64'(WE), 64'(1));
    chk("t5_wdata", 64'(DATA_W_OUT), 64'(32'hDEADBEEF));
    COMMAND_LATCHED = 1'b1;
    cycle();
    chk("t5_gnt", 64'(obs_gnt), 64'(4'b0010));
    COMMAND_LATCHED = 1'b0;
    for (int k = 0; k < RL + 2; k++) begin
      rand_clients(0);
      DATA_R = $urandom;
      cycle();
      chk("t5_no_rvalid", 64'(RDATA_VALID), 64'(0));
    end

    // Asynchronous reset with two reads in flight.
    drain();
    REQ = 4'b0101; REQ_WE = '0; COMMAND_LATCHED = 1'b0;
    cycle();
    COMMAND_LATCHED = 1'b1;
    cycle();
    rand_clients(0);
    cycle();
    rand_clients(0);
    COMMAND_LATCHED = 1'b0;
    cycle();
    #2 RST = 1'b0;
    #1 chk_all_zero("async_rst");
    REQ = '0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < RL + 3; k++) begin
      DATA_R = $urandom;
      cycle();
    end

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      rand_clients(60);
      COMMAND_LATCHED = ($urandom % 2) == 1;
      DATA_R = $urandom;
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
